quadgen_unpack16x4: RTL and testbench

//  4-channel pattern generator: playback counterpart of the quad capture path. Host pushes 16-bit words
//  (same block format the capture packer writes: per 16-sample block, words CH0,CH1,CH2,CH3; first sample
//  in bit15; tail block left-aligned). Block buffers words, unpacks them, drives sig_out at Fs=Fclk/(DIV+1).

---
 rtl/quadgen_unpack16x4_pkg.sv | 19 +
 rtl/pg_word_fifo.sv | 55 +++++
 rtl/quadgen_unpack16x4.sv | 213 +++++++++++++++++++++
 tb/tb_quadgen_unpack16x4.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/quadgen_unpack16x4_pkg.sv
// Shared constants for the quad pattern generator: FSM encoding and block geometry.
package quadgen_unpack16x4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int WORDS_PER_BLK = 4;
  localparam int BLK_SAMPLES   = 16;

  // Number of 16-sample blocks that cover the requested sample count.
  function automatic logic [28:0] blocks_needed(input logic [31:0] samples);
    return {1'b0, samples[31:4]} + {28'd0, |samples[3:0]};
  endfunction

endpackage

// File: rtl/pg_word_fifo.sv
// 16-bit synchronous word FIFO with registered read data, synchronous clear and fill level.
module pg_word_fifo #(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_wr,
  input  logic [15:0]   i_wdata,
  input  logic          i_rd,
  output logic [15:0]   o_rdata,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level
);

  localparam int DEPTH = 1 << AW;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic [15:0]   r_rdata;
  logic          w_do_wr;
  logic          w_do_rd;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == DEPTH[AW:0]);
  assign o_level = r_cnt;
  assign o_rdata = r_rdata;
  assign w_do_wr = i_wr && !o_full;
  assign w_do_rd = i_rd && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_wr && !i_rst && !i_clr) r_mem[r_wp] <= i_wdata;
  end

  // Clear and reset both win over a same-cycle write.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_do_wr) r_wp <= r_wp + AW'(1);
      if (w_do_rd) begin
        r_rdata <= r_mem[r_rp];
        r_rp    <= r_rp + AW'(1);
      end
      r_cnt <= r_cnt + {{AW{1'b0}}, w_do_wr} - {{AW{1'b0}}, w_do_rd};
    end
  end

endmodule

// File: rtl/quadgen_unpack16x4.sv
// Four-channel pattern playback: unpacks CH0..CH3 word blocks from a FIFO into sig_out at Fclk/(div+1).
//   state | meaning
//   IDLE  | outputs parked, waiting for start
//   LOAD  | waiting for first staged block, then copy into shifters
//   PLAY  | ticking samples out, refilling shifters at block ends
//   DONE  | one cycle: raise done, park outputs
module quadgen_unpack16x4
  import quadgen_unpack16x4_pkg::*;
#(
  parameter int         FIFO_AW    = 10,
  parameter logic [3:0] IDLE_LEVEL = 4'b0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_valid,
  input  logic [15:0] i_wr_word,
  input  logic        i_enable_level,
  input  logic [31:0] i_div_value,
  input  logic [31:0] i_cycles_value,
  input  logic        i_start_pulse_in,
  input  logic        i_stop_pulse,
  input  logic        i_fifo_clr_pulse,
  output logic [3:0]  o_sig_out,
  output logic        o_sig_oe,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_underrun,
  output logic        o_empty,
  output logic        o_full,
  output logic [13:0] o_level,
  output logic        o_irq
);

  state_t        r_state;
  logic [31:0]   r_div;
  logic [31:0]   r_left;
  logic [4:0]    r_step;
  logic [31:0]   r_div_cnt;
  logic [28:0]   r_blk_left;
  logic [15:0]   r_sh  [4];
  logic [15:0]   r_stg [4];
  logic          r_stg_valid;
  logic          r_filling;
  logic [2:0]    r_pops;
  logic [1:0]    r_caps;
  logic          r_rd_vld;
  logic [3:0]    r_sig_out;
  logic          r_sig_oe;
  logic          r_done;
  logic          r_underrun;

  logic [FIFO_AW:0] w_level;
  logic [15:0]      w_rdata;
  logic             w_pop;
  logic             w_fill_start;
  logic [15:0]      w_src [4];
  logic [4:0]       w_cnt;
  logic             w_have;
  logic             w_due;
  logic             w_tick;

  pg_word_fifo #(.AW(FIFO_AW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_fifo_clr_pulse),
    .i_wr    (i_wr_valid),
    .i_wdata (i_wr_word),
    .i_rd    (w_pop),
    .o_rdata (w_rdata),
    .o_empty (o_empty),
    .o_full  (o_full),
    .o_level (w_level)
  );

  // A block is popped only as a whole, and only while more blocks are owed.
  assign w_fill_start = (r_state == ST_LOAD || r_state == ST_PLAY) && !r_filling && !r_stg_valid &&
                        (r_blk_left != '0) && (w_level >= (FIFO_AW+1)'(WORDS_PER_BLK)) &&
                        !i_fifo_clr_pulse && !i_stop_pulse;
  assign w_pop   = r_filling && (r_pops != 3'(WORDS_PER_BLK)) && !i_fifo_clr_pulse && !i_stop_pulse;
  assign w_cnt   = (r_left >= 32'(BLK_SAMPLES)) ? 5'(BLK_SAMPLES) : r_left[4:0];
  assign w_have  = (r_step != 5'd0) || r_stg_valid;
  assign w_due   = i_enable_level && (r_div_cnt == '0);
  assign w_tick  = (r_state == ST_PLAY) && w_due && w_have;

  always_comb begin
    for (int k = 0; k < 4; k++) w_src[k] = (r_step == 5'd0) ? r_stg[k] : r_sh[k];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_left      <= '0;
      r_step      <= '0;
      r_div_cnt   <= '0;
      r_blk_left  <= '0;
      r_stg_valid <= 1'b0;
      r_filling   <= 1'b0;
      r_pops      <= '0;
      r_caps      <= '0;
      r_rd_vld    <= 1'b0;
      r_sig_out   <= IDLE_LEVEL;
      r_sig_oe    <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_sh[k]  <= '0;
        r_stg[k] <= '0;
      end
    end else begin
      r_rd_vld <= w_pop;
      if (w_fill_start) begin
        r_filling <= 1'b1;
        r_pops    <= '0;
        r_caps    <= '0;
      end else if (w_pop) begin
        r_pops <= r_pops + 3'd1;
      end
      if (r_rd_vld) begin
        for (int k = 0; k < 3; k++) r_stg[k] <= r_stg[k+1];
        r_stg[3] <= w_rdata;
        r_caps   <= r_caps + 2'd1;
        if (r_caps == 2'(WORDS_PER_BLK - 1)) begin
          r_stg_valid <= 1'b1;
          r_filling   <= 1'b0;
          r_blk_left  <= r_blk_left - 29'd1;
        end
      end
      if (i_fifo_clr_pulse) begin
        r_filling <= 1'b0;
        r_rd_vld  <= 1'b0;
        r_caps    <= '0;
      end

      if (i_stop_pulse && r_state != ST_IDLE) begin
        r_state     <= ST_IDLE;
        r_sig_out   <= IDLE_LEVEL;
        r_sig_oe    <= 1'b0;
        r_stg_valid <= 1'b0;
        r_filling   <= 1'b0;
        r_rd_vld    <= 1'b0;
        r_caps      <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start_pulse_in && !i_stop_pulse) begin
              r_div      <= i_div_value;
              r_left     <= i_cycles_value;
              r_blk_left <= blocks_needed(i_cycles_value);
              r_step     <= '0;
              r_done     <= 1'b0;
              r_underrun <= 1'b0;
              r_state    <= (i_cycles_value == '0) ? ST_DONE : ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (r_stg_valid) begin
              for (int k = 0; k < 4; k++) r_sh[k] <= r_stg[k];
              r_stg_valid <= 1'b0;
              r_step      <= w_cnt;
              r_div_cnt   <= r_div;
              r_sig_oe    <= 1'b1;
              r_state     <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (w_tick) begin
              // At a block end the staged block feeds this tick directly, so cadence has no gap.
              for (int k = 0; k < 4; k++) begin
                r_sig_out[k] <= w_src[k][15];
                r_sh[k]      <= {w_src[k][14:0], 1'b0};
              end
              if (r_step == 5'd0) begin
                r_stg_valid <= 1'b0;
                r_step      <= w_cnt - 5'd1;
              end else begin
                r_step <= r_step - 5'd1;
              end
              r_left    <= r_left - 32'd1;
              r_div_cnt <= r_div;
              if (r_left == 32'd1) r_state <= ST_DONE;
            end else begin
              if (r_step == 5'd0 && r_stg_valid) begin
                for (int k = 0; k < 4; k++) r_sh[k] <= r_stg[k];
                r_stg_valid <= 1'b0;
                r_step      <= w_cnt;
              end
              if (w_due && !w_have) r_underrun <= 1'b1;
              else if (i_enable_level && r_div_cnt != '0) r_div_cnt <= r_div_cnt - 32'd1;
            end
          end
          ST_DONE: begin
            r_done      <= 1'b1;
            r_sig_out   <= IDLE_LEVEL;
            r_sig_oe    <= 1'b0;
            r_stg_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_sig_out  = r_sig_out;
  assign o_sig_oe   = r_sig_oe;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_underrun = r_underrun;
  assign o_level    = 14'(w_level);
  assign o_irq      = r_done | r_underrun;

endmodule

// File: tb/tb_quadgen_unpack16x4.sv
// Bench for quadgen_unpack16x4: directed scenarios plus random playback against a word-stream sample model.
module tb_quadgen_unpack16x4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wr_valid = 1'b0;
  logic [15:0] i_wr_word = '0;
  logic        i_enable_level = 1'b1;
  logic [31:0] i_div_value = '0;
  logic [31:0] i_cycles_value = '0;
  logic        i_start_pulse_in = 1'b0;
  logic        i_stop_pulse = 1'b0;
  logic        i_fifo_clr_pulse = 1'b0;
  logic [3:0]  o_sig_out;
  logic        o_sig_oe;
  logic        o_busy;
  logic        o_done;
  logic        o_underrun;
  logic        o_empty;
  logic        o_full;
  logic [13:0] o_level;
  logic        o_irq;

  int total = 0;
  int bad   = 0;
  logic [15:0] q_words[$];

  always #5 i_clk = ~i_clk;

  quadgen_unpack16x4 #(.FIFO_AW(10), .IDLE_LEVEL(4'b0000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_valid(i_wr_valid), .i_wr_word(i_wr_word),
    .i_enable_level(i_enable_level), .i_div_value(i_div_value), .i_cycles_value(i_cycles_value),
    .i_start_pulse_in(i_start_pulse_in), .i_stop_pulse(i_stop_pulse), .i_fifo_clr_pulse(i_fifo_clr_pulse),
    .o_sig_out(o_sig_out), .o_sig_oe(o_sig_oe), .o_busy(o_busy), .o_done(o_done),
    .o_underrun(o_underrun), .o_empty(o_empty), .o_full(o_full), .o_level(o_level), .o_irq(o_irq)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample n of the stream: block n/16, bit (15 - n%16) of words CH0..CH3 of that block.
  function automatic logic [3:0] model_sample(input int n);
    logic [3:0] s;
    int b;
    int i;
    b = n / 16;
    i = n % 16;
    for (int k = 0; k < 4; k++) s[k] = q_words[b*4 + k][15 - i];
    return s;
  endfunction

  task automatic push(input logic [15:0] w);
    i_wr_valid = 1'b1;
    i_wr_word  = w;
    q_words.push_back(w);
    @(negedge i_clk);
    i_wr_valid = 1'b0;
  endtask

  task automatic clr_fifo();
    i_fifo_clr_pulse = 1'b1;
    i_wr_valid       = 1'b1;
    i_wr_word        = 16'hBEEF;
    @(negedge i_clk);
    i_fifo_clr_pulse = 1'b0;
    i_wr_valid       = 1'b0;
    chk("clr_level", 32'(o_level), 32'd0);
    chk("clr_empty", 32'(o_empty), 32'd1);
    q_words.delete();
  endtask

  task automatic start(input int d, input int cyc);
    i_div_value      = 32'(d);
    i_cycles_value   = 32'(cyc);
    i_start_pulse_in = 1'b1;
    @(negedge i_clk);
    i_start_pulse_in = 1'b0;
  endtask

  task automatic wait_oe();
    int n;
    n = 0;
    while (o_sig_oe !== 1'b1 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("oe_rise", 32'(o_sig_oe), 32'd1);
  endtask

  task automatic play(input int d, input int cyc, input int pause_at);
    logic [3:0] prev;
    logic [3:0] exp_s;
    start(d, cyc);
    wait_oe();
    prev = 4'b0000;
    for (int n = 0; n < cyc; n++) begin
      if (n == pause_at) begin
        i_enable_level = 1'b0;
        repeat (5) begin
          @(negedge i_clk);
          chk("pause_hold", 32'(o_sig_out), 32'(prev));
        end
        i_enable_level = 1'b1;
      end
      repeat (d + 1) @(posedge i_clk);
      @(negedge i_clk);
      exp_s = model_sample(n);
      chk($sformatf("sample%0d", n), 32'(o_sig_out), 32'(exp_s));
      prev = exp_s;
    end
    @(negedge i_clk);
    chk("done_set",  32'(o_done),    32'd1);
    chk("busy_clr",  32'(o_busy),    32'd0);
    chk("oe_clr",    32'(o_sig_oe),  32'd0);
    chk("out_idle",  32'(o_sig_out), 32'd0);
    for (int j = 0; j < ((cyc + 15) / 16) * 4; j++) void'(q_words.pop_front());
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_out",   32'(o_sig_out),  32'd0);
    chk("rst_oe",    32'(o_sig_oe),   32'd0);
    chk("rst_busy",  32'(o_busy),     32'd0);
    chk("rst_done",  32'(o_done),     32'd0);
    chk("rst_under", 32'(o_underrun), 32'd0);
    chk("rst_empty", 32'(o_empty),    32'd1);
    chk("rst_level", 32'(o_level),    32'd0);
    chk("rst_irq",   32'(o_irq),      32'd0);

    // 1: basic block, div=0
    push(16'h8000); push(16'h0000); push(16'hFFFF); push(16'hAAAA);
    play(0, 16, -1);
    chk("t1_level", 32'(o_level), 32'd0);

    // 2: tail block, pad bits discarded
    push(16'hF800); push(16'h0000); push(16'h0000); push(16'h0000);
    play(0, 5, -1);
    chk("t2_level", 32'(o_level), 32'd0);

    // 3: underrun after first block, resume on late data
    for (int k = 0; k < 4; k++) push(16'($urandom) | 16'h0001);
    start(0, 32);
    wait_oe();
    for (int n = 0; n < 16; n++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk("t3_sample", 32'(o_sig_out), 32'(model_sample(n)));
    end
    repeat (3) @(negedge i_clk);
    chk("t3_underrun", 32'(o_underrun), 32'd1);
    chk("t3_busy",     32'(o_busy),     32'd1);
    chk("t3_held",     32'(o_sig_out),  32'hF);
    for (int k = 0; k < 4; k++) push(16'($urandom) & 16'h7FFF);
    begin
      int n;
      n = 0;
      while (o_sig_out == 4'hF && n < 50) begin
        @(negedge i_clk);
        n++;
      end
    end
    chk("t3_resume", 32'(o_sig_out), 32'(model_sample(16)));
    for (int n = 17; n < 32; n++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      chk("t3_sample", 32'(o_sig_out), 32'(model_sample(n)));
    end
    @(negedge i_clk);
    chk("t3_done", 32'(o_done),     32'd1);
    chk("t3_irq",  32'(o_irq),      32'd1);
    chk("t3_usty", 32'(o_underrun), 32'd1);
    q_words.delete();

    // 4: zero-length run pops nothing
    for (int k = 0; k < 4; k++) push(16'($urandom));
    i_div_value      = 32'd3;
    i_cycles_value   = 32'd0;
    i_start_pulse_in = 1'b1;
    @(negedge i_clk);
    i_start_pulse_in = 1'b0;
    chk("t4_oe0", 32'(o_sig_oe), 32'd0);
    @(negedge i_clk);
    chk("t4_oe1",  32'(o_sig_oe), 32'd0);
    chk("t4_done", 32'(o_done),   32'd1);
    chk("t4_level", 32'(o_level), 32'd4);
    clr_fifo();

    // 5: stop mid-play
    for (int k = 0; k < 8; k++) push(16'($urandom));
    start(1, 32);
    wait_oe();
    repeat (6) @(negedge i_clk);
    i_stop_pulse = 1'b1;
    @(negedge i_clk);
    i_stop_pulse = 1'b0;
    chk("t5_out",  32'(o_sig_out), 32'd0);
    chk("t5_oe",   32'(o_sig_oe),  32'd0);
    chk("t5_done", 32'(o_done),    32'd0);
    chk("t5_busy", 32'(o_busy),    32'd0);
    clr_fifo();

    // random playback with pauses
    for (int it = 0; it < 6; it++) begin
      int nblk;
      int cyc;
      int d;
      int extra;
      int pa;
      nblk  = int'($urandom_range(1, 3));
      cyc   = int'($urandom_range(1, 32'(nblk * 16)));
      d     = int'($urandom_range(0, 3));
      extra = int'($urandom_range(0, 6));
      pa    = -1;
      if (cyc > 2) pa = int'($urandom_range(1, 32'(cyc - 1)));
      for (int j = 0; j < ((cyc + 15) / 16) * 4 + extra; j++) push(16'($urandom));
      play(d, cyc, pa);
      chk("rnd_level", 32'(o_level),    32'(extra));
      chk("rnd_under", 32'(o_underrun), 32'd0);
      clr_fifo();
    end

    // 6: fill to capacity, then reset mid-play
    i_wr_valid = 1'b1;
    for (int i = 0; i < 1025; i++) begin
      i_wr_word = 16'(i);
      @(negedge i_clk);
    end
    i_wr_valid = 1'b0;
    chk("t6_level", 32'(o_level), 32'd1024);
    chk("t6_full",  32'(o_full),  32'd1);
    start(0, 64);
    wait_oe();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("t6_out",   32'(o_sig_out),  32'd0);
    chk("t6_oe",    32'(o_sig_oe),   32'd0);
    chk("t6_busy",  32'(o_busy),     32'd0);
    chk("t6_done",  32'(o_done),     32'd0);
    chk("t6_under", 32'(o_underrun), 32'd0);
    chk("t6_lvl0",  32'(o_level),    32'd0);
    chk("t6_empty", 32'(o_empty),    32'd1);
    chk("t6_irq",   32'(o_irq),      32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
